read_miss_handler_fork: RTL and testbench
=========================================

Name: read_miss_handler_fork

Overview:
Parametrised read-miss handler. Joins returning memory read data with the oldest pending read request from the miss request FIFO, and buffers up to DEPTH joined entries. Each entry is forked in order to two sinks: the reorder buffer (ROB) as {id, data}, and the cache fill arbiter as {addr, data}. The two sinks complete independently. Sits between the DRAM read-return channel and the ROB / fill arbiter.

Parameters:
DATA_W, 512, line data width
ADDR_W, 64, request address width
ID_W, 10, request/ROB tag width
DEPTH, 4, pending-entry buffer depth; power of 2, at least 2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid_i  in  1  read-return data valid
ready_o  out  1  read-return data accepted
data_i  in  DATA_W  read-return line data
read_en_o  out  1  pop request FIFO (first-word fall-through)
empty_i  in  1  request FIFO empty
ar_i  in  ID_W+ADDR_W  FIFO head request {id, addr}
write_en_o  out  1  ROB push
full_i  in  1  ROB full
wdata_ROB_o  out  ID_W+DATA_W  {id, data}
valid_o  out  1  fill request valid
ready_i  in  1  fill arbiter ready
wdata_Arbiter_o  out  ADDR_W+DATA_W  {addr, data}
fill_en_i  in  1  mode: 1 = fill the cache, 0 = ROB only (uncacheable)
err_o  out  1  sticky protocol error
pend_cnt_o  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst=1 at a clk edge): count, pointers and err_o clear; all entries are invalidated.
  - All outputs except ready_o/read_en_o are 0 from the next cycle.
  - A reset during activity discards pending entries. No stale beat is emitted after release.
- Accept (combinational):
  - ready_o = !empty_i && (count < DEPTH).
  - read_en_o = valid_i && ready_o.
  - On accept, write entry[wr_ptr] = {id, addr, data}, with rob_done=0 and arb_done=!fill_en_i (fill_en_i sampled at accept).
- Output is from the head entry only, strictly in order:
  - write_en_o = head_valid && !rob_done && !full_i. This is a one-cycle push per entry.
  - valid_o = head_valid && !arb_done.
  - Once valid_o is asserted, it and wdata_Arbiter_o hold stable until ready_i.
  - Output payloads are driven from registered storage. They are 0 when head is invalid.
- Done bits:
  - rob_done sets on write_en_o.
  - arb_done sets on valid_o && ready_i.
- Retire: the head retires in the cycle both done bits are effectively set, counting same-cycle completions. rd_ptr then advances.
  - At most one retire per cycle.
- Count: accept and retire in the same cycle leave count unchanged. Pointers wrap modulo DEPTH. pend_cnt_o = count.
- Latency: data accepted at cycle T appears on the ROB/arbiter outputs at T+1 when the buffer was empty. Sustained throughput is 1 line/cycle with both sinks ready.
- Error: valid_i && empty_i sets err_o at the next cycle.
  - Data arriving with no outstanding request is a protocol violation.
  - The beat is not accepted. err_o is cleared only by rst.
- Full buffer: ready_o=0 and read_en_o=0. The FIFO head and data_i must be held by their sources.

Decomposition:
- Package rmh_pkg holds:
  - default widths and depth localparams;
  - typedef rmh_entry_t {id, addr, data, rob_done, arb_done};
  - packing helpers for the ROB and arbiter payloads.
- One sub-module, rmh_entry_buf: circular storage with wr/rd pointers, count, and per-entry done-bit update. The top holds the join, the fork and the error logic.

Test Plan:
1. Base beat (DEPTH=4): ar_i={10'h005,64'hab}, data_i=512'hcc, valid_i=1, full_i=0, ready_i=1, fill_en_i=1 -> next cycle write_en_o=1 with wdata_ROB_o={10'h005,512'hcc}, and valid_o=1 with wdata_Arbiter_o={64'hab,512'hcc}. Entry retires; pend_cnt_o=0 the cycle after.
2. Arbiter stall: ready_i=0, offer 5 beats with ids 1..5 -> 4 accepted, then ready_o=0 and read_en_o=0 on the 5th. ROB receives id 1 only; head blocks in order. Raise ready_i -> 4 fills drain in order 1..4, the ROB pushes ids 2..4 in turn, and beat 5 is accepted once a slot frees.
3. ROB stall: full_i=1, ready_i=1, one beat id 7 -> valid_o pulses once for id 7, then 0. pend_cnt_o holds 1 and write_en_o stays 0. Drop full_i -> one write_en_o pulse with id 7, then retire.
4. Mode: fill_en_i=0 at accept of id 9 -> only write_en_o pulses and valid_o stays 0. Entry retires after the ROB push.
5. Protocol error: valid_i=1, empty_i=1 -> ready_o=0, read_en_o=0, err_o=1 the next cycle. err_o stays 1 after valid_i drops, until rst.
6. Reset mid-operation: 3 entries pending with ready_i=0, full_i=1, then rst for one cycle -> pend_cnt_o=0, valid_o=0, write_en_o=0. Releasing the stalls emits nothing.

Source files
------------

// File: rtl/rmh_pkg.sv
// Shared widths, the pending-entry layout and payload packing helpers for the
// read-miss handler.
package rmh_pkg;

  localparam int DATA_W_DEF = 512;
  localparam int ADDR_W_DEF = 64;
  localparam int ID_W_DEF   = 10;
  localparam int DEPTH_DEF  = 4;

  typedef struct packed {
    logic [ID_W_DEF-1:0]   id;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
    logic                  rob_done;
    logic                  arb_done;
  } rmh_entry_t;

  function automatic logic [ID_W_DEF+DATA_W_DEF-1:0] pack_rob(input rmh_entry_t e);
    return {e.id, e.data};
  endfunction

  function automatic logic [ADDR_W_DEF+DATA_W_DEF-1:0] pack_arb(input rmh_entry_t e);
    return {e.addr, e.data};
  endfunction

endpackage

// File: rtl/rmh_entry_buf.sv
// Circular buffer of joined miss entries. Tracks per-entry ROB/arbiter completion
// and retires the head once both sinks have taken it.
module rmh_entry_buf #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 64,
  parameter int ID_W   = 10,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [ID_W-1:0]        push_id,
  input  logic [ADDR_W-1:0]      push_addr,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   push_arb_done,
  input  logic                   rob_fire,
  input  logic                   arb_fire,
  output logic                   head_valid,
  output logic [ID_W-1:0]        head_id,
  output logic [ADDR_W-1:0]      head_addr,
  output logic [DATA_W-1:0]      head_data,
  output logic                   head_rob_done,
  output logic                   head_arb_done,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } payload_t;

  payload_t       mem [DEPTH];
  logic [DEPTH-1:0] rob_done_q, arb_done_q;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [PW:0]    count_q;
  logic           retire;

  assign count         = count_q;
  assign head_valid    = (count_q != '0);
  assign head_rob_done = rob_done_q[rd_ptr];
  assign head_arb_done = arb_done_q[rd_ptr];
  assign retire        = head_valid && (head_rob_done || rob_fire) && (head_arb_done || arb_fire);

  // NOTE: outputs assigned a default first so no path through the block leaves a latch.
  always_comb begin
    head_id   = '0;
    head_addr = '0;
    head_data = '0;
    if (head_valid) begin
      head_id   = mem[rd_ptr].id;
      head_addr = mem[rd_ptr].addr;
      head_data = mem[rd_ptr].data;
    end
  end

  // NOTE: payload storage is not reset; count gates every read, so stale words are never seen.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{id: push_id, addr: push_addr, data: push_data};
  end

  // NOTE: state uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      rob_done_q <= '0;
      arb_done_q <= '0;
    end else begin
      // wr_ptr and rd_ptr only coincide when empty (no fire) or full (no push).
      if (push) begin
        wr_ptr             <= wr_ptr + 1'b1;
        rob_done_q[wr_ptr] <= 1'b0;
        arb_done_q[wr_ptr] <= push_arb_done;
      end
      if (rob_fire) rob_done_q[rd_ptr] <= 1'b1;
      if (arb_fire) arb_done_q[rd_ptr] <= 1'b1;
      if (retire)   rd_ptr <= rd_ptr + 1'b1;
      if (push && !retire)      count_q <= count_q + 1'b1;
      else if (!push && retire) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/read_miss_handler_fork.sv
// Joins DRAM read-return beats with the oldest miss request, buffers the result
// and forks each entry in order to the ROB and the cache fill arbiter.
module read_miss_handler_fork
  import rmh_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ID_W   = ID_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [DATA_W-1:0]        data_i,
  output logic                     read_en_o,
  input  logic                     empty_i,
  input  logic [ID_W+ADDR_W-1:0]   ar_i,
  output logic                     write_en_o,
  input  logic                     full_i,
  output logic [ID_W+DATA_W-1:0]   wdata_ROB_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [ADDR_W+DATA_W-1:0] wdata_Arbiter_o,
  input  logic                     fill_en_i,
  output logic                     err_o,
  output logic [$clog2(DEPTH):0]   pend_cnt_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic              head_valid, head_rob_done, head_arb_done;
  logic [ID_W-1:0]   head_id;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  // A beat is only taken together with a request at the FIFO head.
  assign ready_o   = !empty_i && (pend_cnt_o < DEPTH_C);
  assign read_en_o = valid_i && ready_o;

  assign write_en_o      = head_valid && !head_rob_done && !full_i;
  assign valid_o         = head_valid && !head_arb_done;
  assign wdata_ROB_o     = {head_id, head_data};
  assign wdata_Arbiter_o = {head_addr, head_data};

  rmh_entry_buf #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH)
  ) u_buf (
    .clk          (clk),
    .rst          (rst),
    .push         (read_en_o),
    .push_id      (ar_i[ID_W+ADDR_W-1:ADDR_W]),
    .push_addr    (ar_i[ADDR_W-1:0]),
    .push_data    (data_i),
    .push_arb_done(!fill_en_i),
    .rob_fire     (write_en_o),
    .arb_fire     (valid_o && ready_i),
    .head_valid   (head_valid),
    .head_id      (head_id),
    .head_addr    (head_addr),
    .head_data    (head_data),
    .head_rob_done(head_rob_done),
    .head_arb_done(head_arb_done),
    .count        (pend_cnt_o)
  );

  // Data with no outstanding request is a source bug; latch it until reset.
  always_ff @(posedge clk) begin
    if (rst)                       err_o <= 1'b0;
    else if (valid_i && empty_i)   err_o <= 1'b1;
  end

endmodule

// File: tb/tb_read_miss_handler_fork.sv
// Scoreboard bench for read_miss_handler_fork: a request/data source model and
// in-order expected queues for the ROB and fill arbiter sinks.
module tb_read_miss_handler_fork;
  import rmh_pkg::*;

  localparam int DW = DATA_W_DEF;
  localparam int AW = ADDR_W_DEF;
  localparam int IW = ID_W_DEF;
  localparam int DP = DEPTH_DEF;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 valid_i, ready_o, read_en_o, empty_i;
  logic [DW-1:0]        data_i;
  logic [IW+AW-1:0]     ar_i;
  logic                 write_en_o, full_i, valid_o, ready_i, fill_en_i, err_o;
  logic [IW+DW-1:0]     wdata_ROB_o;
  logic [AW+DW-1:0]     wdata_Arbiter_o;
  logic [$clog2(DP):0]  pend_cnt_o;

  read_miss_handler_fork dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .read_en_o(read_en_o), .empty_i(empty_i), .ar_i(ar_i), .write_en_o(write_en_o),
    .full_i(full_i), .wdata_ROB_o(wdata_ROB_o), .valid_o(valid_o), .ready_i(ready_i),
    .wdata_Arbiter_o(wdata_Arbiter_o), .fill_en_i(fill_en_i), .err_o(err_o),
    .pend_cnt_o(pend_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          fill;
  } beat_t;

  beat_t            src_q[$];
  logic [IW+DW-1:0] rob_q[$];
  logic [AW+DW-1:0] arb_q[$];
  int total = 0, bad = 0;
  int rob_cnt = 0, arb_cnt = 0, rob_base, arb_base;
  logic inject_err = 1'b0;
  logic prev_stall = 1'b0;
  logic [AW+DW-1:0] prev_arb;

  task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic add_beat(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic fill);
    beat_t b;
    rmh_entry_t e;
    b.id = id; b.addr = addr; b.data = data; b.fill = fill;
    src_q.push_back(b);
    e.id = id; e.addr = addr; e.data = data; e.rob_done = 1'b0; e.arb_done = !fill;
    rob_q.push_back(pack_rob(e));
    if (fill) arb_q.push_back(pack_arb(e));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Source model plus sink monitor: sample at negedge, then drive the next beat.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("arb_hold", {valid_o, wdata_Arbiter_o}, {1'b1, prev_arb});
        if (write_en_o) begin
          rob_cnt++;
          if (rob_q.size() == 0) check("rob_unexpected", write_en_o, 1'b0);
          else check("rob_data", wdata_ROB_o, rob_q.pop_front());
        end
        if (valid_o && ready_i) begin
          arb_cnt++;
          if (arb_q.size() == 0) check("arb_unexpected", valid_o, 1'b0);
          else check("arb_data", wdata_Arbiter_o, arb_q.pop_front());
        end
        prev_stall = valid_o && !ready_i;
        prev_arb   = wdata_Arbiter_o;
        if (read_en_o && src_q.size() != 0) void'(src_q.pop_front());
      end
      if (src_q.size() != 0) begin
        empty_i   = 1'b0;
        valid_i   = 1'b1;
        ar_i      = {src_q[0].id, src_q[0].addr};
        data_i    = src_q[0].data;
        fill_en_i = src_q[0].fill;
      end else begin
        empty_i = 1'b1;
        valid_i = inject_err;
        ar_i    = '0;
        data_i  = '0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid_i = 1'b0; empty_i = 1'b1; data_i = '0; ar_i = '0;
    full_i = 1'b0; ready_i = 1'b0; fill_en_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_pend", pend_cnt_o, 0);
    check("rst_wen", write_en_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_err", err_o, 0);
    check("rst_rob", wdata_ROB_o, 0);
    check("rst_arb", wdata_Arbiter_o, 0);

    // Base beat: visible one cycle after accept, retires the next.
    ready_i = 1'b1;
    add_beat(10'h005, 64'hab, 512'hcc, 1'b1);
    step();
    check("t1_wen", write_en_o, 1);
    check("t1_valid", valid_o, 1);
    check("t1_rob", wdata_ROB_o, {10'h005, 512'hcc});
    check("t1_arb", wdata_Arbiter_o, {64'hab, 512'hcc});
    step();
    check("t1_pend", pend_cnt_o, 0);
    check("t1_wen_off", write_en_o, 0);

    // Arbiter stall: buffer fills, fifth beat back-pressured.
    ready_i = 1'b0;
    rob_base = rob_cnt; arb_base = arb_cnt;
    for (int i = 1; i <= 5; i++) add_beat(IW'(i), AW'(64'h1000 + i), DW'(32'hd00 + i), 1'b1);
    repeat (8) step();
    check("t2_pend_full", pend_cnt_o, DP);
    check("t2_ready", ready_o, 0);
    check("t2_rden", read_en_o, 0);
    check("t2_rob_one", rob_cnt - rob_base, 1);
    check("t2_arb_none", arb_cnt - arb_base, 0);
    ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (src_q.size() == 0 && pend_cnt_o == 0) break;
      step();
    end
    check("t2_drain_pend", pend_cnt_o, 0);
    check("t2_drain_src", src_q.size(), 0);
    check("t2_rob_all", rob_cnt - rob_base, 5);
    check("t2_arb_all", arb_cnt - arb_base, 5);

    // ROB stall: fill completes first, ROB push follows when full_i drops.
    full_i = 1'b1;
    add_beat(10'd7, 64'h77, 512'h7070, 1'b1);
    step();
    check("t3_valid", valid_o, 1);
    check("t3_wen", write_en_o, 0);
    step();
    check("t3_valid_off", valid_o, 0);
    check("t3_pend", pend_cnt_o, 1);
    check("t3_wen_stall", write_en_o, 0);
    full_i = 1'b0;
    #1 check("t3_wen_go", write_en_o, 1);
    step();
    check("t3_retire", pend_cnt_o, 0);
    check("t3_wen_done", write_en_o, 0);

    // Uncacheable: ROB only.
    add_beat(10'd9, 64'h99, 512'h9090, 1'b0);
    step();
    check("t4_wen", write_en_o, 1);
    check("t4_valid", valid_o, 0);
    step();
    check("t4_pend", pend_cnt_o, 0);

    // Protocol error is sticky.
    check("t5_err_pre", err_o, 0);
    inject_err = 1'b1;
    step();
    check("t5_err", err_o, 1);
    check("t5_ready", ready_o, 0);
    check("t5_rden", read_en_o, 0);
    inject_err = 1'b0;
    step(); step();
    check("t5_err_sticky", err_o, 1);
    check("t5_pend", pend_cnt_o, 0);

    // Reset with entries pending discards them.
    ready_i = 1'b0; full_i = 1'b1;
    for (int i = 0; i < 3; i++) add_beat(IW'(20 + i), AW'(64'h2000 + i), DW'(32'he00 + i), 1'b1);
    repeat (5) step();
    check("t6_pend_pre", pend_cnt_o, 3);
    rst = 1'b1;
    rob_q.delete(); arb_q.delete();
    step();
    rst = 1'b0;
    check("t6_pend", pend_cnt_o, 0);
    check("t6_valid", valid_o, 0);
    check("t6_wen", write_en_o, 0);
    check("t6_err", err_o, 0);
    rob_base = rob_cnt; arb_base = arb_cnt;
    ready_i = 1'b1; full_i = 1'b0;
    repeat (6) step();
    check("t6_no_rob", rob_cnt - rob_base, 0);
    check("t6_no_arb", arb_cnt - arb_base, 0);
    check("t6_pend_post", pend_cnt_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
